// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: state encodings and default width.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/fs_bit_cell.sv
// One-bit full subtractor: d = x - y - bin, bo set when the bit underflows.
module fs_bit_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bin;
  assign bo   = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell time-shared LSB first,
// with a start/busy/done handshake around it.
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned    CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_d_sh;
  logic             r_br;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_d_sh_next;

  fs_bit_cell u_cell (
    .x   (r_a_sh[0]),
    .y   (r_b_sh[0]),
    .bin (r_br),
    .d   (w_d),
    .bo  (w_bo)
  );

  // New bit enters at the MSB; the concatenation keeps WIDTH=1 free of empty slices.
  assign w_d_sh_next = WIDTH'({w_d, r_d_sh} >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_d_sh <= w_d_sh_next;
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_br   <= w_bo;
          r_cnt  <= r_cnt + CntW'(1);
          if (r_cnt == CntLast) begin
            r_diff   <= w_d_sh_next;
            r_borrow <= w_bo;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign done       = (r_state == ST_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed plus randomized bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8, bin8, busy8, done8, bo8;
  logic [7:0] a8, b8, diff8;
  logic       s1, bin1, busy1, done1, bo1;
  logic [0:0] a1, b1, diff1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] prev_d8, prev_d1;
  logic        prev_b8, prev_b1;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (s8),
    .a          (a8),
    .b          (b8),
    .bin        (bin8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bo8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (s1),
    .a          (a1),
    .b          (b1),
    .bin        (bin1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (bo1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w1, input logic st, input logic [31:0] a,
                       input logic [31:0] b, input logic bi);
    if (w1) begin
      s1 = st; a1 = a[0]; b1 = b[0]; bin1 = bi;
    end else begin
      s8 = st; a8 = a[7:0]; b8 = b[7:0]; bin8 = bi;
    end
  endtask

  task automatic chk_outs(input bit w1, input string tag, input logic eb_busy,
                          input logic e_done, input logic [31:0] e_diff, input logic e_bo);
    chk({tag, "/busy"}, w1 ? 32'(busy1) : 32'(busy8), 32'(eb_busy));
    chk({tag, "/done"}, w1 ? 32'(done1) : 32'(done8), 32'(e_done));
    chk({tag, "/diff"}, w1 ? 32'(diff1) : 32'(diff8), e_diff);
    chk({tag, "/bo"},   w1 ? 32'(bo1)   : 32'(bo8),   32'(e_bo));
  endtask

  // Starts one op from IDLE and follows it cycle by cycle until back in IDLE.
  // noisy: start stays high and operands churn while busy, which must be ignored.
  task automatic run_op(input bit w1, input logic [31:0] a_in, input logic [31:0] b_in,
                        input logic bi, input bit noisy, input string tag);
    int unsigned w;
    logic [31:0] mask, a, b, ed, pd;
    logic        eb, pb;
    longint      t;
    w    = w1 ? 1 : 8;
    mask = (32'd1 << w) - 32'd1;
    a    = a_in & mask;
    b    = b_in & mask;
    t    = longint'(a) - longint'(b) - longint'(bi);
    eb   = (t < 0);
    ed   = t[31:0] & mask;
    pd   = w1 ? prev_d1 : prev_d8;
    pb   = w1 ? prev_b1 : prev_b8;
    drive(w1, 1'b1, a, b, bi);
    tick();
    for (int k = 1; k <= int'(w) + 1; k++) begin
      if (k == int'(w) + 1) chk_outs(w1, tag, 1'b1, 1'b1, ed, eb);
      else                  chk_outs(w1, tag, 1'b1, 1'b0, pd, pb);
      if (noisy) drive(w1, 1'b1, $urandom, $urandom, 1'($urandom));
      else       drive(w1, 1'b0, a, b, bi);
      tick();
    end
    drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
    chk_outs(w1, {tag, "/idle"}, 1'b0, 1'b0, ed, eb);
    if (w1) begin prev_d1 = ed; prev_b1 = eb; end
    else    begin prev_d8 = ed; prev_b8 = eb; end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 1'b0);
    tick();
    tick();
    chk_outs(1'b0, "reset8", 1'b0, 1'b0, 0, 1'b0);
    chk_outs(1'b1, "reset1", 1'b0, 1'b0, 0, 1'b0);
    prev_d8 = 0; prev_b8 = 1'b0; prev_d1 = 0; prev_b1 = 1'b0;
    rst = 1'b0;
    tick();

    run_op(1'b0, 100, 58, 1'b0, 1'b0, "t1");
    run_op(1'b0, 5, 10, 1'b0, 1'b0, "t2a");
    run_op(1'b0, 0, 0, 1'b1, 1'b0, "t2b");
    run_op(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, "t2c");
    run_op(1'b0, 200, 1, 1'b0, 1'b1, "t3");

    // Abort mid-run: outputs clear and the aborted op never signals done.
    drive(1'b0, 1'b1, 9, 4, 1'b0);
    tick();
    drive(1'b0, 1'b0, 9, 4, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_outs(1'b0, "t4rst", 1'b0, 1'b0, 0, 1'b0);
    prev_d8 = 0; prev_b8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4quiet/done", 32'(done8), 0);
    end
    run_op(1'b0, 9, 4, 1'b0, 1'b0, "t4b");

    // start held high: a result every WIDTH+2 cycles.
    drive(1'b0, 1'b1, 20, 7, 1'b0);
    tick();
    for (int j = 1; j <= 30; j++) begin
      chk("t5/done", 32'(done8), 32'((j % 10) == 9));
      chk("t5/busy", 32'(busy8), 32'((j % 10) != 0));
      chk("t5/diff", 32'(diff8), (j >= 9) ? 32'd13 : prev_d8);
      if (j == 29) s8 = 1'b0;
      if (j < 30) tick();
    end
    prev_d8 = 13; prev_b8 = 1'b0;

    for (int i = 0; i < 20; i++)
      run_op(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), "rnd8");

    run_op(1'b1, 0, 1, 1'b0, 1'b0, "t6");
    for (int v = 0; v < 8; v++)
      run_op(1'b1, 32'((v >> 2) & 1), 32'((v >> 1) & 1), 1'(v), 1'(v), "t6sweep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
